hls_deadlock_param_monitor: RTL
===============================

# hls_deadlock_param_monitor

Parametrised deadlock monitor for one HLS dataflow instance. It generalises the fixed two-stream monitor to NUM_AXIS stream-block inputs and NUM_INST sub-instance idle/block inputs. Block is declared only after the stall condition persists for THRESHOLD cycles, with optional sticky latching, source capture and stall-duration reporting. One instance sits per monitored HLS module in the deadlock-detection tree; its `block` output feeds the parent monitor's `inst_block_sigs`.

## Interface
- NUM_AXIS, 2: number of AXI-stream block inputs, 1..32.
- NUM_INST, 1: number of monitored sub-instances, 0..32. With 0, the sub-instance term is constant 0.
- THRESHOLD, 1: consecutive stalled cycles before block is declared, 1..2^CNT_W-1.
- STICKY, 0: 1 means block holds until `clear`; 0 means it self-clears when the stall ends.
- CNT_W, 16: width of the persistence and duration counters.

Ports (clock and reset first):
- clock  in  1  sole clock; all logic is rising-edge.
- reset_n  in  1  asynchronous, active-low reset. Assertion is immediate; deassertion is synchronised externally.
- clear  in  1  synchronous pulse; returns the FSM to IDLE and zeroes the counters and captures.
- axis_block_sigs  in  NUM_AXIS  per-stream blocked flags.
- inst_idle_sigs  in  max(NUM_INST,1)  per-sub-instance idle.
- inst_block_sigs  in  max(NUM_INST,1)  per-sub-instance blocked.
- block  out  1  deadlock declared; registered.
- block_src  out  NUM_AXIS+NUM_INST  snapshot of the stall sources at the declaring cycle. Streams occupy the LSBs; instance block bits sit above them.
- block_cycles  out  CNT_W  saturating count of cycles spent in DEADLOCK.
- mon_state  out  2  current FSM state, for debug.

## Operation
- Stall condition `cond` (combinational) = any stream term OR all-sub term.
  - any stream term: OR of axis_block_sigs.
  - all-sub term: every sub-instance is (idle OR blocked) AND at least one is blocked.
- FSM states: IDLE=0, SUSPECT=1, DEADLOCK=2. Encoding 3 is unreachable and decodes to IDLE.
- IDLE: if cond, then persist_cnt <= 1. Go to DEADLOCK if THRESHOLD==1, else SUSPECT.
- SUSPECT: if cond is low, go to IDLE and set persist_cnt <= 0. If cond is high, increment persist_cnt; when the incremented value equals THRESHOLD, go to DEADLOCK.
- On entry to DEADLOCK: block_src <= {instance block bits, axis_block_sigs} sampled that cycle; block_cycles <= 0.
- DEADLOCK: block_cycles increments every cycle and saturates at all-ones.
  - STICKY=0 and cond low: go to IDLE. block_src and block_cycles keep their last values until the next entry.
  - STICKY=1: stay in DEADLOCK regardless of cond.
- block = registered (next_state == DEADLOCK).
- `clear` takes priority over every transition: state IDLE, all counters 0, block_src 0, block 0 on the next edge.
- Simultaneous clear and cond: clear wins. Counting restarts on the following cycle.

## Timing
- Reset values: block=0, block_src=0, block_cycles=0, mon_state=IDLE, persist_cnt=0.
- Latency: cond first high at edge k and held → block high after edge k+THRESHOLD-1.
  - With THRESHOLD=1 this is one cycle after the condition, the same as the legacy monitor.
- STICKY=0 release: cond low at edge m → block low after edge m.
- A gap of one cycle in cond during SUSPECT restarts counting from 0.
- reset_n asserted mid-stall: all outputs return to reset values asynchronously.
- No combinational path from any input to any output.

## Structure
- Package `hls_deadlock_pkg` holds:
  - the state enum (IDLE/SUSPECT/DEADLOCK) and the MON_STATE_W=2 constant;
  - the function computing the all-sub term for a given NUM_INST.
- Sub-module `hls_deadlock_sat_counter`, with parameter W and ports clock, reset_n, clr, inc, q. It saturates at 2^W-1 and is instantiated twice: persistence count and block duration.
- The top level holds the cond logic, the FSM and the capture registers.

## Test plan
- THRESHOLD=1, NUM_AXIS=2, NUM_INST=1: pulse axis_block_sigs=2'b10 for one cycle → block high for exactly one cycle, one cycle later; block_src=3'b010.
- THRESHOLD=4: cond held 3 cycles, dropped 1, then held 4 → no block during the first burst; block rises after the 4th cycle of the second burst.
- NUM_INST=3, axis_block_sigs=0, idle=3'b011, block=3'b100, THRESHOLD=2 → block after 2 cycles.
  - Then idle=3'b001, block=3'b100 → cond low; with STICKY=0, block falls the next cycle.
- STICKY=1, CNT_W=4: stall 2 cycles then release → block stays high; block_cycles saturates at 15.
  - Pulse clear → block=0, block_src=0, block_cycles=0 next edge.
- Assert reset_n low mid-DEADLOCK between clock edges → outputs 0 immediately. Release and re-stall → normal THRESHOLD latency.
- Assert clear and a fresh cond in the same cycle → state IDLE. Block is declared THRESHOLD cycles after cond resumes.

Source files
------------

// File: rtl/hls_deadlock_param_monitor_pkg.sv
// Shared definitions for the parametrised HLS deadlock monitor.
// Contents:
//   MON_STATE_W      - width of the debug state output
//   mon_state_e      - FSM state encoding (IDLE/SUSPECT/DEADLOCK)
//   MAX_INST         - upper bound on monitored sub-instances
//   all_sub_stalled  - "every sub-instance idle or blocked, and at least one blocked"
package hls_deadlock_pkg;

    localparam int unsigned MON_STATE_W = 2;
    localparam int unsigned MAX_INST    = 32;

    typedef enum logic [MON_STATE_W-1:0] {
        MON_IDLE     = 2'd0,
        MON_SUSPECT  = 2'd1,
        MON_DEADLOCK = 2'd2
    } mon_state_e;

    // With no sub-instances the term is constant 0 so an empty group never stalls.
    function automatic logic all_sub_stalled(
        input logic [MAX_INST-1:0] idle,
        input logic [MAX_INST-1:0] blk,
        input int unsigned         num_inst
    );
        logic all_ok;
        logic any_blk;
        all_ok  = 1'b1;
        any_blk = 1'b0;
        for (int unsigned i = 0; i < MAX_INST; i++) begin
            if (i < num_inst) begin
                if (!(idle[i] | blk[i])) all_ok  = 1'b0;
                if (blk[i])              any_blk = 1'b1;
            end
        end
        return (num_inst != 0) && all_ok && any_blk;
    endfunction

endpackage

// File: rtl/hls_deadlock_param_monitor_if.sv
// Bus bundle between a deadlock monitor and its environment.
//   master : drives clear / stream-block / sub-instance idle+block, observes results
//   slave  : the monitor itself
// Signals: clear, axis_block_sigs[NUM_AXIS], inst_idle_sigs/inst_block_sigs[max(NUM_INST,1)],
//          block, block_src[NUM_AXIS+NUM_INST], block_cycles[CNT_W], mon_state[2].
interface hls_deadlock_param_monitor_if
    import hls_deadlock_pkg::*;
#(
    parameter int unsigned NUM_AXIS = 2,
    parameter int unsigned NUM_INST = 1,
    parameter int unsigned CNT_W    = 16
);
    localparam int unsigned INST_W = (NUM_INST == 0) ? 1 : NUM_INST;
    localparam int unsigned SRC_W  = NUM_AXIS + NUM_INST;

    logic                   clear;
    logic [NUM_AXIS-1:0]    axis_block_sigs;
    logic [INST_W-1:0]      inst_idle_sigs;
    logic [INST_W-1:0]      inst_block_sigs;
    logic                   block;
    logic [SRC_W-1:0]       block_src;
    logic [CNT_W-1:0]       block_cycles;
    logic [MON_STATE_W-1:0] mon_state;

    modport master (
        output clear, axis_block_sigs, inst_idle_sigs, inst_block_sigs,
        input  block, block_src, block_cycles, mon_state
    );

    modport slave (
        input  clear, axis_block_sigs, inst_idle_sigs, inst_block_sigs,
        output block, block_src, block_cycles, mon_state
    );
endinterface

// File: rtl/hls_deadlock_param_monitor_sat_counter.sv
// Saturating up-counter used for stall persistence and deadlock duration.
// Ports: clock, reset_n (async active-low), clr (sync clear, wins over inc),
//        inc (count enable), q (count, sticks at 2^W-1).
module hls_deadlock_sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear first, otherwise step until all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign q = cnt_q;
endmodule

// File: rtl/hls_deadlock_param_monitor.sv
// Deadlock monitor for one HLS dataflow instance.
// Declares block once the stall condition (any stream blocked, or all sub-instances
// idle/blocked with at least one blocked) has held for THRESHOLD cycles.
// Ports: clock, reset_n (async active-low), bus (slave modport: clear, stream and
//        sub-instance flags in; block, block_src, block_cycles, mon_state out).
// All outputs come straight from registers.
module hls_deadlock_param_monitor
    import hls_deadlock_pkg::*;
#(
    parameter int unsigned NUM_AXIS  = 2,
    parameter int unsigned NUM_INST  = 1,
    parameter int unsigned THRESHOLD = 1,
    parameter int unsigned STICKY    = 0,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                          clock,
    input  logic                          reset_n,
    hls_deadlock_param_monitor_if.slave   bus
);
    localparam int unsigned SRC_W = NUM_AXIS + NUM_INST;

    localparam logic [MON_STATE_W-1:0] S_IDLE     = MON_IDLE;
    localparam logic [MON_STATE_W-1:0] S_SUSPECT  = MON_SUSPECT;
    localparam logic [MON_STATE_W-1:0] S_DEADLOCK = MON_DEADLOCK;

    logic [MON_STATE_W-1:0] state_q;
    logic [MON_STATE_W-1:0] state_d;
    logic                   block_q;
    logic [SRC_W-1:0]       block_src_q;
    logic [SRC_W-1:0]       block_src_d;
    logic [CNT_W-1:0]       persist_q;
    logic [CNT_W-1:0]       dur_q;
    logic [SRC_W-1:0]       src_c;
    logic                   cond_c;
    logic                   enter_c;

    // Stall condition.
    assign cond_c = (|bus.axis_block_sigs)
                  | all_sub_stalled(MAX_INST'(bus.inst_idle_sigs),
                                    MAX_INST'(bus.inst_block_sigs), NUM_INST);

    // Capture vector: stream flags in the LSBs, instance block flags above.
    if (NUM_INST > 0) begin : g_src_inst
        assign src_c = {bus.inst_block_sigs[NUM_INST-1:0], bus.axis_block_sigs};
    end else begin : g_src_axis
        assign src_c = bus.axis_block_sigs;
    end

    // Next state; encoding 3 falls into the default arm and behaves as IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_SUSPECT: begin
                if (!cond_c) begin
                    state_d = S_IDLE;
                end else if (persist_q == CNT_W'(THRESHOLD - 1)) begin
                    state_d = S_DEADLOCK;
                end
            end
            S_DEADLOCK: begin
                if ((STICKY == 0) && !cond_c) state_d = S_IDLE;
            end
            default: begin
                if (cond_c) state_d = (THRESHOLD == 1) ? S_DEADLOCK : S_SUSPECT;
                else        state_d = S_IDLE;
            end
        endcase
        if (bus.clear) state_d = S_IDLE;
    end

    assign enter_c = (state_q != S_DEADLOCK) && (state_d == S_DEADLOCK);

    // Source snapshot is taken only on entry and held until the next entry or clear.
    always_comb begin
        block_src_d = block_src_q;
        if (bus.clear)    block_src_d = '0;
        else if (enter_c) block_src_d = src_c;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            block_q     <= 1'b0;
            block_src_q <= '0;
        end else begin
            state_q     <= state_d;
            block_q     <= (state_d == S_DEADLOCK);
            block_src_q <= block_src_d;
        end
    end

    // Persistence: zero outside a running stall, so IDLE always counts up from 0.
    hls_deadlock_sat_counter #(.W(CNT_W)) u_persist (
        .clock   (clock),
        .reset_n (reset_n),
        .clr     (bus.clear | ~cond_c | (state_q == S_DEADLOCK)),
        .inc     (cond_c),
        .q       (persist_q)
    );

    // Duration: restarts on entry, counts each cycle spent in DEADLOCK.
    hls_deadlock_sat_counter #(.W(CNT_W)) u_duration (
        .clock   (clock),
        .reset_n (reset_n),
        .clr     (bus.clear | enter_c),
        .inc     (state_q == S_DEADLOCK),
        .q       (dur_q)
    );

    assign bus.block        = block_q;
    assign bus.block_src    = block_src_q;
    assign bus.block_cycles = dur_q;
    assign bus.mon_state    = state_q;
endmodule
